// File: rtl/mux_rr_arb.sv
// Registered N-to-1 mux with valid/ready handshake, fixed-select or round-robin grant.
// Define MUX_RR_PKT_LOCK_EN to keep multi-beat packets from one channel together.
module mux_rr_arb #(
   parameter int unsigned N  = 32,
   parameter int unsigned W  = 32,
   parameter int unsigned SW = $clog2(N)
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           mode_i,
   input  logic [SW-1:0]  sel_i,
   input  logic [N*W-1:0] d_i,
   input  logic [N-1:0]   valid_i,
   input  logic [N-1:0]   last_i,
   output logic [N-1:0]   ready_o,
   output logic [W-1:0]   y_o,
   output logic           valid_o,
   output logic           last_o,
   output logic [SW-1:0]  sel_o,
   input  logic           ready_i
);

   logic          le;
   logic          xfer;
   logic          grant_valid;
   logic [SW-1:0] cand;
   logic [SW-1:0] ptr_q;
   logic          rr_found;
   logic [SW-1:0] rr_idx;
   logic [SW-1:0] k_idx;

`ifdef MUX_RR_PKT_LOCK_EN
   typedef enum logic {UNLOCKED, LOCKED} lock_state_e;
   lock_state_e   lock_state_q, lock_state_d;
   logic [SW-1:0] lock_ch_q, lock_ch_d;
`endif

   assign le = !valid_o | ready_i;

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      k_idx    = '0;
      for (int i = 1; i <= int'(N); i++) begin
         k_idx = SW'((32'(ptr_q) + 32'(i)) % N);
         if (!rr_found && valid_i[k_idx]) begin
            rr_found = 1'b1;
            rr_idx   = k_idx;
         end
      end
   end

   // Candidate selection; an active lock overrides mode and select.
   always_comb begin
      cand        = rr_idx;
      grant_valid = rr_found;
      if (!mode_i) begin
         cand        = sel_i;
         grant_valid = (32'(sel_i) < N) && valid_i[sel_i];
      end
`ifdef MUX_RR_PKT_LOCK_EN
      if (lock_state_q == LOCKED) begin
         cand        = lock_ch_q;
         grant_valid = valid_i[lock_ch_q];
      end
`endif
   end

   // Reset gating keeps any beat from being accepted while rst_ni is low.
   assign xfer    = rst_ni & le & grant_valid;
   assign ready_o = xfer ? (N'(1) << cand) : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         y_o     <= '0;
         valid_o <= 1'b0;
         last_o  <= 1'b0;
         sel_o   <= '0;
         ptr_q   <= SW'(N - 1);
      end else if (xfer) begin
         y_o     <= d_i[32'(cand)*W +: W];
         valid_o <= 1'b1;
         last_o  <= last_i[cand];
         sel_o   <= cand;
         ptr_q   <= cand;
      end else if (le) begin
         valid_o <= 1'b0;
      end
   end

`ifdef MUX_RR_PKT_LOCK_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_state_q <= UNLOCKED;
         lock_ch_q    <= '0;
      end else begin
         lock_state_q <= lock_state_d;
         lock_ch_q    <= lock_ch_d;
      end
   end

   always_comb begin
      lock_state_d = lock_state_q;
      lock_ch_d    = lock_ch_q;
      case (lock_state_q)
         UNLOCKED: if (xfer && !last_i[cand]) begin
            lock_state_d = LOCKED;
            lock_ch_d    = cand;
         end
         LOCKED: if (xfer && last_i[cand]) lock_state_d = UNLOCKED;
         default: lock_state_d = UNLOCKED;
      endcase
   end
`endif

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed self-checking bench for mux_rr_arb (N=32, W=32, d[k]=A000_0000+k).
// Expectations for the packet-lock scenario follow MUX_RR_PKT_LOCK_EN.
module tb_mux_rr_arb;
   localparam int unsigned N  = 32;
   localparam int unsigned W  = 32;
   localparam int unsigned SW = 5;

   logic           clk;
   logic           rst_n;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [N*W-1:0] d;
   logic [N-1:0]   valid_in;
   logic [N-1:0]   last_in;
   logic [N-1:0]   ready_out;
   logic [W-1:0]   y;
   logic           valid_out;
   logic           last_out;
   logic [SW-1:0]  sel_out;
   logic           ready_in;

   int checks   = 0;
   int failures = 0;

   mux_rr_arb #(.N(N), .W(W)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .mode_i  (mode),
      .sel_i   (sel),
      .d_i     (d),
      .valid_i (valid_in),
      .last_i  (last_in),
      .ready_o (ready_out),
      .y_o     (y),
      .valid_o (valid_out),
      .last_o  (last_out),
      .sel_o   (sel_out),
      .ready_i (ready_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [SW-1:0] sel;
      logic [W-1:0]  exp_y;
      logic [SW-1:0] exp_sel;
      logic [N-1:0]  exp_ready;
   } vec_t;

   vec_t vecs[32];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_beat(input string name, input int ch);
      check({name, " sel_o"}, 64'(sel_out), 64'(ch));
      check({name, " y_o"}, 64'(y), 64'(32'hA000_0000 + ch));
      check({name, " valid_o"}, 64'(valid_out), 64'd1);
   endtask

   int rr_exp[6] = '{3, 7, 31, 3, 7, 31};
`ifdef MUX_RR_PKT_LOCK_EN
   int lk_sel[$]  = '{5, 5, 5, 6};
   int lk_last[$] = '{0, 0, 1, 0};
`else
   int lk_sel[$]  = '{5, 6, 5, 6, 5};
   int lk_last[$] = '{0, 0, 0, 0, 1};
`endif

   initial begin
      int ch5;
      rst_n    = 1'b0;
      mode     = 1'b0;
      sel      = '0;
      valid_in = '0;
      last_in  = '0;
      ready_in = 1'b1;
      for (int k = 0; k < int'(N); k++) d[k*W +: W] = 32'hA000_0000 + 32'(k);
      for (int i = 0; i < 32; i++) begin
         vecs[i].sel       = SW'(i);
         vecs[i].exp_y     = 32'hA000_0000 + 32'(i);
         vecs[i].exp_sel   = SW'(i);
         vecs[i].exp_ready = 32'h1 << i;
      end

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst ready_o in reset", 64'(ready_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst y_o", 64'(y), 64'd0);
      check("rst valid_o", 64'(valid_out), 64'd0);
      check("rst last_o", 64'(last_out), 64'd0);
      check("rst sel_o", 64'(sel_out), 64'd0);
      check("rst ready_o", 64'(ready_out), 64'd0);
      step();

      // Fixed-select sweep, all channels valid
      mode     = 1'b0;
      valid_in = '1;
      for (int i = 0; i < 32; i++) begin
         sel = vecs[i].sel;
         #1;
         check("fixed ready_o", 64'(ready_out), 64'(vecs[i].exp_ready));
         step();
         check("fixed y_o", 64'(y), 64'(vecs[i].exp_y));
         check("fixed sel_o", 64'(sel_out), 64'(vecs[i].exp_sel));
         check("fixed valid_o", 64'(valid_out), 64'd1);
      end

      // Round-robin over channels 3, 7, 31
      mode     = 1'b1;
      valid_in = (32'h1 << 3) | (32'h1 << 7) | (32'h1 << 31);
      for (int i = 0; i < 6; i++) begin
         step();
         expect_beat("rr", rr_exp[i]);
      end

      // Backpressure holds beat 31, then resumes with 3, 7
      ready_in = 1'b0;
      #1;
      check("bp ready_o", 64'(ready_out), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         expect_beat("bp hold", 31);
         check("bp hold ready_o", 64'(ready_out), 64'd0);
      end
      ready_in = 1'b1;
      step();
      expect_beat("bp resume0", 3);
      step();
      expect_beat("bp resume1", 7);

      // Wrap-around 31 -> 0 -> 31
      valid_in = 32'h1 << 31;
      step();
      expect_beat("wrap a", 31);
      valid_in = (32'h1 << 31) | 32'h1;
      step();
      expect_beat("wrap b", 0);
      step();
      expect_beat("wrap c", 31);

      // Fixed select on an idle channel: no grant, beat drained, data held
      mode     = 1'b0;
      sel      = 5'd4;
      valid_in = 32'h1 << 5;
      #1;
      check("nogrant ready_o", 64'(ready_out), 64'd0);
      step();
      check("nogrant valid_o", 64'(valid_out), 64'd0);
      check("nogrant sel_o", 64'(sel_out), 64'd31);
      check("nogrant y_o", 64'(y), 64'(32'hA000_001F));

      // Packet of 3 beats on ch5 against continuously valid ch6
      mode    = 1'b1;
      last_in = '0;
      ch5     = 0;
      for (int b = 0; b < lk_sel.size(); b++) begin
         valid_in    = 32'h1 << 6;
         valid_in[5] = (ch5 < 3);
         last_in[5]  = (ch5 == 2);
         #1;
         if (ready_out[5]) ch5++;
         step();
         expect_beat("lock", lk_sel[b]);
         check("lock last_o", 64'(last_out), 64'(lk_last[b]));
      end

      // Asynchronous reset during streaming
      last_in  = '0;
      valid_in = '1;
      step();
      step();
      check("arst pre valid_o", 64'(valid_out), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst valid_o", 64'(valid_out), 64'd0);
      check("arst y_o", 64'(y), 64'd0);
      check("arst sel_o", 64'(sel_out), 64'd0);
      check("arst ready_o", 64'(ready_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      expect_beat("arst first", 0);
      step();
      expect_beat("arst second", 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_rr_arb.md
# mux_rr_arb

Parametrised, registered N-to-1 multiplexer with per-channel valid/ready handshake and two selection modes: fixed select or round-robin arbitration. It is the sequential successor of the team's combinational 32-to-1 mux. It sits wherever several producers share one downstream consumer, such as register-file read-out or bus funnels, and drives a single registered output beat.

## Interface
- `N`, 32, number of input channels (2..64)
- `W`, 32, data width per channel
- `SW`, `$clog2(N)`, select/grant index width (derived; do not override)
- `clk_i`  in  1  clock, all state on rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `mode_i`  in  1  0 = fixed select via `sel_i`, 1 = round-robin
- `sel_i`  in  SW  channel index used when `mode_i`=0
- `d_i`  in  N*W  flattened inputs; channel k occupies bits [k*W+W-1 : k*W]
- `valid_i`  in  N  per-channel beat valid
- `last_i`  in  N  per-channel end-of-packet flag
- `ready_o`  out  N  per-channel accept, at most one bit set
- `y_o`  out  W  registered output data
- `valid_o`  out  1  output beat valid
- `last_o`  out  1  `last_i` of the granted beat, registered
- `sel_o`  out  SW  index of the channel that produced `y_o`
- `ready_i`  in  1  downstream accept

## Operation
- Load enable is `le = !valid_o | ready_i`. It gives a single output stage with full throughput and no bubbles.
- Grant selection is combinational from current inputs and state.
  - Fixed mode: candidate = `sel_i`. Grant is valid only if `sel_i` < N and `valid_i[sel_i]`.
  - Round-robin mode: candidate = first k with `valid_i[k]`, searching `ptr+1, ptr+2, …` modulo N (wrap N-1 → 0).
- `ready_o[g] = le & grant_valid`. All other `ready_o` bits are 0. `ready_o` never depends on `ready_i` when `valid_o`=0.
- Input transfer occurs when `valid_i[g] & ready_o[g]`. On transfer:
  - `y_o` ← d[g]; `sel_o` ← g; `last_o` ← `last_i[g]`; `valid_o` ← 1
  - `ptr` ← g, in both modes, so a switch to round-robin continues from the last grant.
- If `le` is set and there is no grant, `valid_o` ← 0. `y_o`, `sel_o` and `last_o` hold their old values.
- While `valid_o & !ready_i`, all outputs are frozen.
- `mode_i`/`sel_i` changes affect only the next grant and never the held beat.
- Lock FSM (only with the macro): UNLOCKED → LOCKED(g) on transfer with `last_i[g]`=0. LOCKED(g) → UNLOCKED on transfer from g with `last_i[g]`=1. While LOCKED, the candidate is forced to g regardless of mode, `sel_i` or other valids.

## Timing
- Latency: input transfer at edge t, data on `y_o` with `valid_o`=1 after edge t.
- Throughput: one beat per cycle while `ready_i`=1.
- Reset values: `y_o`=0, `valid_o`=0, `last_o`=0, `sel_o`=0, `ready_o` is combinational (0 while all `valid_i`=0), `ptr`=N-1 (first round-robin grant is channel 0), lock state UNLOCKED.
- Reset asserted mid-operation clears the held beat and the lock immediately (asynchronous). No beat is accepted in the cycle `rst_ni` is low.
- Simultaneous downstream drain and upstream transfer in one cycle is legal and is the normal streaming case.

## Configuration
- `MUX_RR_PKT_LOCK_EN` defined: the lock FSM is compiled in. Multi-beat packets from one channel are never interleaved.
- Undefined: no lock state. `last_i` is only forwarded to `last_o`, and arbitration is per beat.

## Test plan
All scenarios use N=32, W=32, d[k]=32'hA000_0000+k.
- Fixed mode, all `valid_i`=1, `ready_i`=1, `sel_i` sweeping 0..31 → one cycle later `y_o`=A000_0000+sel, `sel_o`=sel, `ready_o` one-hot at sel.
- Round-robin, `valid_i` set on channels 3, 7 and 31, `ready_i`=1 → `sel_o` sequence 3, 7, 31, 3, 7, … with one beat per cycle and no bubbles.
- Backpressure: `ready_i`=0 while `valid_o`=1 → `y_o`/`sel_o` stable and `ready_o`=0; raising `ready_i` → streaming resumes with no beat lost or duplicated.
- Wrap-around: after a grant to channel 31, `valid_i` on channels 0 and 31 only → next grant is 0, then 31.
- Lock: channel 5 sends 3 beats with last=0,0,1 while channel 6 is continuously valid → with macro, grants are 5, 5, 5, 6; without macro, grants are 5, 6, 5, 6, 5.
- Async reset during streaming → `valid_o` drops without waiting for a clock edge. After release, the first round-robin grant with all channels valid is channel 0.
